// File: rtl/ram4_arbiter_if.sv
// Bundle for the two-requester RAM arbiter: requester handshakes, the single
// memory port, and the FSM state for debug visibility.
interface ram4_arbiter_if;
  // Handshake: a requester raises req with we/addr/wdata stable and holds it
  // until its one-cycle ack; req still high in the cycle after ack is a new request.
  logic       req_a;
  logic       req_b;
  logic       we_a;
  logic       we_b;
  logic [1:0] addr_a;
  logic [1:0] addr_b;
  logic [3:0] wdata_a;
  logic [3:0] wdata_b;
  logic       ack_a;
  logic       ack_b;
  logic [3:0] rdata_a;
  logic [3:0] rdata_b;
  logic       busy;
  logic       mem_sel;
  logic [1:0] mem_addr;
  logic [3:0] mem_din;
  logic [3:0] mem_dout;
  logic [1:0] state_dbg;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_dout,
    output ack_a, ack_b, rdata_a, rdata_b, busy, mem_sel, mem_addr, mem_din,
           state_dbg
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_dout,
    input  ack_a, ack_b, rdata_a, rdata_b, busy, mem_sel, mem_addr, mem_din,
           state_dbg
  );
endinterface

// File: rtl/ram4_arbiter.sv
// Round-robin arbiter sharing one 4x4 synchronous RAM port between requesters
// A and B; each transaction runs IDLE -> ACCESS -> WAIT -> DONE.
module ram4_arbiter (
  input  logic            clk,
  input  logic            reset,
  ram4_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  logic       last_b;
  logic       cur_b;
  logic       cur_we;
  logic [1:0] addr_q;
  logic [3:0] din_q;
  logic       sel_q;
  logic       ack_a_q;
  logic       ack_b_q;
  logic [3:0] rdata_a_q;
  logic [3:0] rdata_b_q;

  logic       grant_b;
  logic       win_we;
  logic [1:0] win_addr;
  logic [3:0] win_wdata;

  // With both pending, the one not granted last time wins.
  always_comb begin
    grant_b = 1'b0;
    if (bus.req_a && bus.req_b) grant_b = ~last_b;
    else                        grant_b = bus.req_b;
    win_we    = grant_b ? bus.we_b    : bus.we_a;
    win_addr  = grant_b ? bus.addr_b  : bus.addr_a;
    win_wdata = grant_b ? bus.wdata_b : bus.wdata_a;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      cur_b     <= 1'b0;
      cur_we    <= 1'b0;
      addr_q    <= 2'd0;
      din_q     <= 4'd0;
      sel_q     <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      rdata_a_q <= 4'd0;
      rdata_b_q <= 4'd0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            state  <= ACCESS;
            cur_b  <= grant_b;
            last_b <= grant_b;
            cur_we <= win_we;
            addr_q <= win_addr;
            din_q  <= win_wdata;
            sel_q  <= win_we;
          end
        end
        ACCESS: begin
          sel_q <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // Read data from the RAM arrives one edge after ACCESS presented the address.
          if (!cur_we) begin
            if (cur_b) rdata_b_q <= bus.mem_dout;
            else       rdata_a_q <= bus.mem_dout;
          end
          ack_a_q <= ~cur_b;
          ack_b_q <= cur_b;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Reset gates the strobe immediately so an aborted write never reaches the RAM.
  assign bus.mem_sel   = sel_q & ~reset;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;
  assign bus.ack_a     = ack_a_q;
  assign bus.ack_b     = ack_b_q;
  assign bus.rdata_a   = rdata_a_q;
  assign bus.rdata_b   = rdata_b_q;
  assign bus.busy      = (state != IDLE);
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_ram4_arbiter.sv
// Directed bench for ram4_arbiter with a behavioural 4x4 RAM and an ack
// scoreboard keyed on requester, ack cycle and read data.
module tb_ram4_arbiter;
  localparam int W = 21;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram4_arbiter_if bus ();
  ram4_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sel_cycles = 0;
  int exp_writes = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [3:0] mem [4];

  // RAM model: write on strobe, registered read one edge after the address.
  always @(posedge clk) begin
    if (bus.mem_sel === 1'b1) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_sel === 1'b1) sel_cycles++;
    if (bus.ack_a === 1'b1 || bus.ack_b === 1'b1) begin
      check("ack_exclusive", 16'(bus.ack_a & bus.ack_b), 16'd0);
      check("ack_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ack_who", 16'(bus.ack_b), 16'(e[20]));
        check("ack_cycle", 16'(cyc), e[19:4]);
        check("ack_rdata", 16'(e[20] ? bus.rdata_b : bus.rdata_a), 16'(e[3:0]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drive(input bit who, input bit we, input logic [1:0] a, input logic [3:0] d);
    if (who) begin
      bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = a; bus.wdata_b = d;
    end else begin
      bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = a; bus.wdata_a = d;
    end
  endtask

  task automatic expect_ack(input bit who, input int at, input logic [3:0] rd);
    exp_q.push_back({who, 16'(at), rd});
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input bit who);
    int n;
    n = 0;
    while (!((who ? bus.ack_b : bus.ack_a) === 1'b1) && n < 12) begin
      tick();
      n++;
    end
    check("ack_timeout", 16'(n < 12), 16'd1);
  endtask

  task automatic run_one(input bit who, input bit we, input logic [1:0] a,
                         input logic [3:0] d, input logic [3:0] exp_rd, input bit perturb);
    drive(who, we, a, d);
    expect_ack(who, cyc + 3, exp_rd);
    if (we) exp_writes++;
    tick();
    check("access_sel", 16'(bus.mem_sel), 16'(we));
    check("access_addr", 16'(bus.mem_addr), 16'(a));
    check("access_din", 16'(bus.mem_din), 16'(d));
    check("access_busy", 16'(bus.busy), 16'd1);
    if (perturb) begin
      if (who) begin bus.addr_b = a + 2'd1; bus.wdata_b = ~d; end
      else     begin bus.addr_a = a + 2'd1; bus.wdata_a = ~d; end
    end
    tick();
    check("wait_sel", 16'(bus.mem_sel), 16'd0);
    check("wait_addr", 16'(bus.mem_addr), 16'(a));
    wait_ack(who);
    tick();
    if (who) bus.req_b = 1'b0; else bus.req_a = 1'b0;
    check("idle_addr_hold", 16'(bus.mem_addr), 16'(a));
    check("idle_busy", 16'(bus.busy), 16'd0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 4; i++) mem[i] = 4'd0;
    reset = 1'b1;
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = 2'd0; bus.wdata_a = 4'd0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = 2'd0; bus.wdata_b = 4'd0;
    tick();
    tick();
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_ack_a", 16'(bus.ack_a), 16'd0);
    check("rst_ack_b", 16'(bus.ack_b), 16'd0);
    check("rst_sel", 16'(bus.mem_sel), 16'd0);
    check("rst_addr", 16'(bus.mem_addr), 16'd0);
    check("rst_din", 16'(bus.mem_din), 16'd0);
    check("rst_rdata_a", 16'(bus.rdata_a), 16'd0);
    check("rst_rdata_b", 16'(bus.rdata_b), 16'd0);
    check("rst_state", 16'(bus.state_dbg), 16'd0);
    reset = 1'b0;

    // A writes 2 = A; rdata_a must stay 0. Then B reads it back.
    run_one(1'b0, 1'b1, 2'd2, 4'hA, 4'h0, 1'b0);
    check("write_keeps_rdata_a", 16'(bus.rdata_a), 16'd0);
    run_one(1'b1, 1'b0, 2'd2, 4'h5, 4'hA, 1'b0);

    // Simultaneous requests after reset: A first, then B while A re-requests, then A.
    do_reset();
    c = cyc;
    drive(1'b0, 1'b1, 2'd1, 4'h2);
    drive(1'b1, 1'b0, 2'd2, 4'h0);
    expect_ack(1'b0, c + 3, 4'h0);
    expect_ack(1'b1, c + 7, 4'hA);
    exp_writes++;
    wait_to(c + 4);
    drive(1'b0, 1'b1, 2'd3, 4'h5);
    expect_ack(1'b0, c + 11, 4'h0);
    exp_writes++;
    wait_to(c + 8);
    bus.req_b = 1'b0;
    wait_to(c + 12);
    bus.req_a = 1'b0;

    // A holds req for three writes while B holds a read of addr 1 (holds 2 from above).
    do_reset();
    c = cyc;
    drive(1'b0, 1'b1, 2'd0, 4'h1);
    drive(1'b1, 1'b0, 2'd1, 4'h0);
    expect_ack(1'b0, c + 3, 4'h0);
    expect_ack(1'b1, c + 7, 4'h2);
    expect_ack(1'b0, c + 11, 4'h0);
    expect_ack(1'b0, c + 15, 4'h0);
    exp_writes += 3;
    wait_to(c + 4);
    drive(1'b0, 1'b1, 2'd1, 4'h2);
    wait_to(c + 8);
    bus.req_b = 1'b0;
    wait_to(c + 12);
    drive(1'b0, 1'b1, 2'd2, 4'h3);
    wait_to(c + 16);
    bus.req_a = 1'b0;
    check("rr_rdata_b", 16'(bus.rdata_b), 16'h2);

    // Reset during ACCESS of a write of F to addr 3: aborted, no ack, RAM untouched.
    drive(1'b0, 1'b1, 2'd3, 4'hF);
    tick();
    check("abort_busy_before", 16'(bus.busy), 16'd1);
    reset = 1'b1;
    #1;
    check("abort_sel", 16'(bus.mem_sel), 16'd0);
    tick();
    reset = 1'b0;
    bus.req_a = 1'b0;
    check("abort_busy", 16'(bus.busy), 16'd0);
    check("abort_ack_a", 16'(bus.ack_a), 16'd0);
    check("abort_sel_after", 16'(bus.mem_sel), 16'd0);
    check("abort_rdata_b", 16'(bus.rdata_b), 16'd0);
    for (int i = 0; i < 4; i++) tick();
    run_one(1'b1, 1'b0, 2'd3, 4'h0, 4'h5, 1'b0);

    // A alters addr/wdata right after grant; memory must see the latched values.
    run_one(1'b0, 1'b1, 2'd0, 4'h6, 4'h0, 1'b1);
    run_one(1'b0, 1'b0, 2'd0, 4'h0, 4'h6, 1'b0);
    run_one(1'b1, 1'b0, 2'd1, 4'h0, 4'h2, 1'b0);

    tick();
    tick();
    check("sel_cycles", 16'(sel_cycles), 16'(exp_writes));
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram4_arbiter.md
RAM4_ARBITER -- requirements
Module: ram4_arbiter

Interface
REQ-001 The block SHALL have the port: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL have the port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the ports: req_a, req_b  input  1  access request from requester A / B; held high until that requester's ack.
REQ-004 The block SHALL have the ports: we_a, we_b  input  1  1 = write, 0 = read; stable while the matching req is high.
REQ-005 The block SHALL have the ports: addr_a, addr_b  input  2  word address; stable while the matching req is high.
REQ-006 The block SHALL have the ports: wdata_a, wdata_b  input  4  write data; stable while the matching req is high.
REQ-007 The block SHALL have the ports: ack_a, ack_b  output  1  one-cycle completion pulse to requester A / B.
REQ-008 The block SHALL have the ports: rdata_a, rdata_b  output  4  registered read data per requester.
REQ-009 The block SHALL have the port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have the port: mem_sel  output  1  memory write strobe (1 = write, 0 = read).
REQ-011 The block SHALL have the port: mem_addr  output  2  memory address.
REQ-012 The block SHALL have the port: mem_din  output  4  memory write data.
REQ-013 The block SHALL have the port: mem_dout  input  4  memory read data; valid one clk edge after the address is presented with mem_sel = 0.

Function
REQ-014 The FSM SHALL have the states IDLE, ACCESS, WAIT and DONE, with one transition per clk edge.
REQ-015 In IDLE, when req_a or req_b is high, the FSM SHALL select a winner, latch the winner's we/addr/wdata and its identity, and go to ACCESS.
REQ-016 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-017 The FSM SHALL go ACCESS -> WAIT -> DONE -> IDLE unconditionally.
REQ-018 Arbitration SHALL be round-robin: with one request pending, that requester wins; with both pending, the requester not granted most recently wins.
REQ-019 The last-grant pointer SHALL update only on a grant.
REQ-020 mem_addr and mem_din SHALL drive the latched addr/wdata from ACCESS through DONE, and SHALL hold their last values in IDLE.
REQ-021 mem_sel SHALL be 1 only during ACCESS of a write transaction and 0 in every other cycle.
REQ-022 For a read, the block SHALL capture mem_dout at the end of WAIT into rdata_x of the winning requester x.
REQ-023 rdata_x SHALL hold its value until the next read completion for requester x; a write SHALL never change rdata_a or rdata_b.
REQ-024 ack_x SHALL be high exactly during DONE of requester x's transaction; ack_a and ack_b SHALL never be high in the same cycle.
REQ-025 Latency SHALL be: req sampled in IDLE at cycle 0 -> ack in cycle 3, for both reads and writes; rdata_x SHALL be valid in the ack cycle.
REQ-026 Throughput SHALL be at most one transaction per 4 cycles.
REQ-027 A requester SHALL drop req in the cycle after its ack; req still high when the FSM re-enters IDLE SHALL be treated as a new transaction.
REQ-028 Changes to req, we, addr or wdata of a requester after it is granted SHALL NOT affect the transaction in flight.
REQ-029 A read issued directly after a write to the same address SHALL return the newly written data.

Reset
REQ-030 While reset is high, the block SHALL force: FSM = IDLE, ack_a = ack_b = 0, busy = 0, mem_sel = 0, mem_addr = 0, mem_din = 0, rdata_a = rdata_b = 0, last-grant = B (so A wins the first conflict).
REQ-031 Reset asserted in ACCESS of a write SHALL take priority: mem_sel SHALL be 0 from that edge on, and no ack SHALL be issued for the aborted transaction.
REQ-032 Memory contents SHALL NOT be cleared by this block.

Verification
REQ-033 The bench SHALL cover: reset, then A writes addr 2 = 4'hA -> mem_sel = 1 for exactly 1 cycle with mem_addr = 2, mem_din = 4'hA; ack_a in cycle 3; rdata_a unchanged (0).
REQ-034 The bench SHALL cover: after REQ-033, B reads addr 2 -> ack_b in cycle 3 with rdata_b = 4'hA; mem_sel stays 0.
REQ-035 The bench SHALL cover: req_a and req_b both asserted in the same cycle directly after reset -> A served first, B acked 4 cycles after ack_a; on a second simultaneous pair, B is served first.
REQ-036 The bench SHALL cover: req_a held high for 3 back-to-back writes (addr 0..2, data 1..3) while req_b is held for a read of addr 1 -> grants alternate A, B, A, A; rdata_b = 4'h2.
REQ-037 The bench SHALL cover: reset pulsed during ACCESS of an A write of 4'hF to addr 3 -> no ack_a, busy = 0 on the next cycle; a following read of addr 3 returns the prior contents.
REQ-038 The bench SHALL cover: A changes addr and wdata in the cycle after its grant -> the memory sees the originally latched values.
